result_tx: RTL and testbench
============================

# result_tx

Result serializer for the matmul accelerator. Accepts 32-bit row results on a valid/ready word stream and emits them to the host as a framed byte stream. Frame: one header byte holding the word count, then each word least-significant byte first, optionally followed by a checksum byte. Sits between the matmul output port and the host byte link, and mirrors the byte-in framing the host already uses toward the accelerator.

## Interface
- `MAX_WORDS`, default 16: largest frame word count supported. Must be ≤ 255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: synchronous reset, active-low.
- `cfg_count` in 8: number of result words in the next frame. Sampled on the `cfg_valid && cfg_ready` handshake.
- `cfg_valid` in 1: frame-start request.
- `cfg_ready` out 1: high only in IDLE.
- `in_data` in 32: result word. Unsigned, passed through unmodified.
- `in_valid` in 1 / `in_ready` out 1: word handshake.
- `out_data` out 8: byte to the host.
- `out_valid` out 1 / `out_ready` in 1: byte handshake.
- `busy` out 1: high in every state except IDLE.

## Operation
- Handshake rule: a transfer occurs on a rising edge where valid && ready.
  - A producer must hold its data stable while valid is high and ready is low.
  - `out_valid` never drops without a transfer.
  - `out_data` is stable while `out_valid && !out_ready`.
- States: IDLE, HEADER, LOAD, SEND, CKSUM.
- IDLE:
  - On a cfg handshake: latch `count = cfg_count` and set `words_left = count`.
  - If `cfg_count > MAX_WORDS`, latch `MAX_WORDS` instead; the header reports the latched value.
  - Clear the checksum, then go to HEADER.
- HEADER:
  - `out_data = count`, `out_valid = 1`; checksum ^= count on transfer.
  - On transfer: go to LOAD if count > 0. If count = 0, go to CKSUM (macro on) or IDLE (macro off).
- LOAD:
  - `in_ready = 1`, `out_valid = 0`.
  - On an input handshake: shift register ← `in_data`, `byte_idx = 0`, go to SEND.
- SEND:
  - `out_data = shift[7:0]`, `out_valid = 1`.
  - On each transfer: checksum ^= byte; shift right 8; `byte_idx++`.
  - On transfer of byte 3: `words_left--`.
    - If `words_left` reaches 0, go to CKSUM or IDLE.
    - Otherwise, if the prefetch buffer is full, move it into the shift register and stay in SEND with `byte_idx = 0`.
    - Otherwise go to LOAD.
- Prefetch buffer (one word):
  - In SEND, `in_ready = !nxt_valid && (words_accepted < count)`.
  - This lets a new word be accepted during byte transmission, so the stream has no bubble between words.
- Input outside a frame: words presented in IDLE or HEADER are not accepted (`in_ready = 0`). Words beyond `count` are never accepted.
- CKSUM (macro on only): `out_data = checksum`, `out_valid = 1`. On transfer go to IDLE.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE; all counters, prefetch and checksum are cleared.
  - Output values: `cfg_ready = 1`, `in_ready = 0`, `out_valid = 0`, `out_data = 0`, `busy = 0`.
  - Reset mid-frame abandons the frame with no trailing bytes.
- All outputs are decoded from registered state. There is no combinational path from `out_ready` or `in_valid` to any output.
- Latency, with `out_ready` held high:
  - Header byte appears 1 cycle after the cfg handshake.
  - First data byte appears 1 cycle after that word's input handshake.
  - Bytes are then continuous, 1 per cycle.
- Steady-state throughput: 4 bytes per word with no idle cycles, provided each next word is offered at least 1 cycle before the current word's last byte.
- A new cfg handshake is possible on the cycle the final byte transfers, because that edge returns the block to IDLE.
- Backpressure: with `out_ready` low, state, byte index and checksum all hold.

## Configuration
- `RESULT_TX_CHECKSUM_EN` defined:
  - CKSUM state exists.
  - Each frame ends with the 8-bit XOR of the header byte and all data bytes.
  - Frame length is 4·count + 2 bytes.
- Undefined:
  - No checksum logic or state; transitions that would enter CKSUM go to IDLE.
  - Frame length is 4·count + 1 bytes.

## Structure
- Shared package `matmul_pkg` holds:
  - the state enumeration (3-bit),
  - `BYTE_W = 8`, `WORD_W = 32`, `BYTES_PER_WORD = 4`,
  - the `MAX_WORDS` default shared with matmul.
- Sub-module `result_tx_skid`: the one-word prefetch buffer (valid/ready in, pop on last-byte transfer, flush on reset).

## Test plan
- cfg_count = 1, word 0x11223344, `out_ready` held high:
  - Bytes out: 01 44 33 22 11, plus checksum 0x45 with the macro on.
  - `busy` falls on the edge of the final transfer.
- cfg_count = 2, words 0xDEADBEEF and 0x00000001 presented back-to-back:
  - Bytes out: 02 EF BE AD DE 01 00 00 00 on 9 consecutive cycles, with no bubble.
- cfg_count = 0:
  - Bytes out: 00, then checksum 00 with the macro on.
  - `in_ready` never asserts.
- cfg_count = 2, `out_ready` toggled 1 0 0 1 …:
  - Byte sequence is identical to the unstalled case.
  - `out_data` is held stable across every stalled cycle.
- `rst_n` pulsed low after 3 data bytes of a count = 3 frame:
  - All outputs return to their reset values.
  - A new frame with count = 1 afterwards is byte-correct.
- cfg_count = 20 with `MAX_WORDS` = 16:
  - Header byte is 0x10.
  - Exactly 16 words are accepted; the 17th offered word sees `in_ready = 0`.

Source files
------------

// File: rtl/matmul_pkg.sv
// Types and constants shared by the matmul accelerator and its result serializer.
// The CKSUM state exists only when RESULT_TX_CHECKSUM_EN is defined.
package matmul_pkg;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LOAD,
        ST_SEND
`ifdef RESULT_TX_CHECKSUM_EN
        , ST_CKSUM
`endif
    } state_t;
endpackage

// File: rtl/result_tx_if.sv
// Handshake bundle of result_tx: frame config, word stream in, byte stream out.
// Identical with or without RESULT_TX_CHECKSUM_EN.
interface result_tx_if;
    import matmul_pkg::*;

    logic [BYTE_W-1:0] cfg_count;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output cfg_count, cfg_valid, in_data, in_valid, out_ready,
        input  cfg_ready, in_ready, out_data, out_valid, busy
    );
    modport slave (
        input  cfg_count, cfg_valid, in_data, in_valid, out_ready,
        output cfg_ready, in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/result_tx_skid.sv
// One-word prefetch buffer so the next word can arrive while the current one is sent.
// Independent of RESULT_TX_CHECKSUM_EN.
module result_tx_skid
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pop,
    output logic              nxt_valid,
    output logic [WORD_W-1:0] nxt_data
);
    assign in_ready = en && !nxt_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nxt_valid <= 1'b0;
            nxt_data  <= '0;
        end else if (in_valid && in_ready) begin
            nxt_valid <= 1'b1;
            nxt_data  <= in_data;
        end else if (pop) begin
            nxt_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/result_tx.sv
// Serializes 32-bit result words into a framed byte stream: count header, LSB-first data,
// plus a trailing XOR checksum byte when RESULT_TX_CHECKSUM_EN is defined.
module result_tx
    import matmul_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input logic        clk,
    input logic        rst_n,
    result_tx_if.slave bus
);
    localparam logic [BYTE_W-1:0] MAX_CNT  = BYTE_W'(MAX_WORDS);
    localparam logic [1:0]        LAST_IDX = 2'(BYTES_PER_WORD - 1);
`ifdef RESULT_TX_CHECKSUM_EN
    localparam state_t END_ST = ST_CKSUM;
`else
    localparam state_t END_ST = ST_IDLE;
`endif

    state_t            state, state_nxt;
    logic [BYTE_W-1:0] count, words_left, words_acc, cnt_clamp;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] shift, nxt_data;
    logic              nxt_valid, skid_ready, acc_lt, in_fire, last_byte, pop;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [BYTE_W-1:0] cksum;
`endif

    assign cnt_clamp = (bus.cfg_count > MAX_CNT) ? MAX_CNT : bus.cfg_count;
    assign acc_lt    = words_acc < count;
    assign in_fire   = bus.in_valid && bus.in_ready;
    assign last_byte = (state == ST_SEND) && bus.out_ready && (byte_idx == LAST_IDX);
    // A word may land in the buffer on the same edge the FSM drops to LOAD; LOAD drains it.
    assign pop = ((state == ST_LOAD) && nxt_valid) ||
                 (last_byte && (words_left != 8'd1) && nxt_valid);

    assign bus.cfg_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.in_ready  = ((state == ST_LOAD) && !nxt_valid && acc_lt) || skid_ready;

    result_tx_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       ((state == ST_SEND) && acc_lt),
        .in_data  (bus.in_data),
        .in_valid (bus.in_valid),
        .in_ready (skid_ready),
        .pop      (pop),
        .nxt_valid(nxt_valid),
        .nxt_data (nxt_data)
    );

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        case (state)
            ST_HEADER: begin bus.out_valid = 1'b1; bus.out_data = count; end
            ST_SEND:   begin bus.out_valid = 1'b1; bus.out_data = shift[BYTE_W-1:0]; end
`ifdef RESULT_TX_CHECKSUM_EN
            ST_CKSUM:  begin bus.out_valid = 1'b1; bus.out_data = cksum; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.cfg_valid) state_nxt = ST_HEADER;
            ST_HEADER: if (bus.out_ready) state_nxt = (count != '0) ? ST_LOAD : END_ST;
            ST_LOAD:   if (nxt_valid || in_fire) state_nxt = ST_SEND;
            ST_SEND: begin
                if (last_byte) begin
                    if (words_left == 8'd1) state_nxt = END_ST;
                    else if (!nxt_valid)    state_nxt = ST_LOAD;
                end
            end
`ifdef RESULT_TX_CHECKSUM_EN
            ST_CKSUM:  if (bus.out_ready) state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            words_left <= '0;
            words_acc  <= '0;
            byte_idx   <= '0;
            shift      <= '0;
        end else begin
            if ((state == ST_IDLE) && bus.cfg_valid) begin
                count      <= cnt_clamp;
                words_left <= cnt_clamp;
                words_acc  <= '0;
            end
            if (in_fire) words_acc <= words_acc + 8'd1;
            if ((state == ST_LOAD) && (nxt_valid || in_fire)) begin
                shift    <= nxt_valid ? nxt_data : bus.in_data;
                byte_idx <= '0;
            end
            if ((state == ST_SEND) && bus.out_ready) begin
                shift    <= shift >> BYTE_W;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == LAST_IDX) begin
                    words_left <= words_left - 8'd1;
                    if (pop) shift <= nxt_data;
                end
            end
        end
    end

`ifdef RESULT_TX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            cksum <= '0;
        else if ((state == ST_IDLE) && bus.cfg_valid)
            cksum <= '0;
        else if ((state == ST_HEADER) && bus.out_ready)
            cksum <= cksum ^ count;
        else if ((state == ST_SEND) && bus.out_ready)
            cksum <= cksum ^ shift[BYTE_W-1:0];
    end
`endif
endmodule

// File: tb/tb_result_tx.sv
// Self-checking bench for result_tx: randomized frames against a byte-level frame model.
module tb_result_tx;
    localparam int MAXW = 16;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    result_tx_if bus();

    result_tx #(.MAX_WORDS(MAXW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] wq[$];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          tq[$];
    int          iq[$];
    int          acc;
    bit          saw_rdy, over_rdy, last_busy;

    // Frame model: header = clamped count, each word LSB first, optional XOR of all prior bytes.
    function automatic void build_exp(input int cnt);
        int         eff;
        logic [7:0] x;
        logic [31:0] w;
        eff = (cnt > MAXW) ? MAXW : cnt;
        exp_q.delete();
        x = 8'(eff);
        exp_q.push_back(8'(eff));
        for (int i = 0; i < eff; i++) begin
            for (int b = 0; b < 4; b++) begin
                w = wq[i] >> (8 * b);
                exp_q.push_back(w[7:0]);
                x = x ^ w[7:0];
            end
        end
        if (CK) exp_q.push_back(x);
    endfunction

    task automatic run_frame(input int cnt, input int rmode, input int gap, input int stop_after);
        int         wi, k, need, eff;
        bit         stalled, fired;
        logic [7:0] held;
        wi = 0; k = 0; stalled = 0; fired = 0; held = '0;
        eff  = (cnt > MAXW) ? MAXW : cnt;
        need = (stop_after >= 0) ? stop_after : 1 + 4 * eff + (CK ? 1 : 0);
        got.delete(); tq.delete(); iq.delete();
        acc = 0; saw_rdy = 0; over_rdy = 0; last_busy = 0;
        bus.cfg_count = 8'(cnt);
        bus.cfg_valid = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            bus.cfg_valid = 1'b0;
            if (fired) begin bus.in_valid = 1'b0; fired = 0; end
            if (got.size() >= need) break;
            if (k > 600) begin
                n_checks++; n_fail++;
                $display("FAIL frame_timeout: got %0d of %0d bytes after %0d cycles", got.size(), need, k);
                break;
            end
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (!bus.in_valid && wi < wq.size() && (gap == 0 || $urandom_range(0, gap) == 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = wq[wi];
            end
            #1;
            if (bus.in_ready) begin saw_rdy = 1; if (acc >= eff) over_rdy = 1; end
            if (stalled) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             bus.out_valid, bus.out_data, held);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data); tq.push_back(k); last_busy = bus.busy;
            end
            if (bus.in_valid && bus.in_ready) begin iq.push_back(k); acc++; wi++; fired = 1; end
            k++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cfg_valid = 0; bus.cfg_count = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b want 1", bus.cfg_ready); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        wq.delete(); wq.push_back(32'h11223344);
        run_frame(1, 0, 0, -1);
        build_exp(1);
        n_checks++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        n_checks++; if (tq.size() < 2 || tq[0] != 0 || iq.size() < 1 || tq[1] != iq[0] + 1) begin
            n_fail++; $display("FAIL single_latency: header/first-byte timing off (%0d entries)", tq.size()); end
        #1;
        n_checks++; if (last_busy !== 1'b1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_busy_fall: busy at last=%b after=%b cfg_ready=%b, want 1 0 1", last_busy, bus.busy, bus.cfg_ready); end
    endtask

    task automatic test_back_to_back();
        wq.delete(); wq.push_back(32'hDEADBEEF); wq.push_back(32'h00000001);
        run_frame(2, 0, 0, -1);
        build_exp(2);
        n_checks++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        for (int i = 2; i < 9 && i < tq.size(); i++) begin
            n_checks++;
            if (tq[i] != tq[i-1] + 1) begin n_fail++; $display("FAIL b2b_bubble: byte %0d at cycle %0d, want %0d", i, tq[i], tq[i-1] + 1); end
        end
    endtask

    task automatic test_zero();
        wq.delete(); wq.push_back(32'hCAFEF00D);
        run_frame(0, 0, 0, -1);
        build_exp(0);
        n_checks++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        n_checks++; if (saw_rdy) begin n_fail++; $display("FAIL zero_in_ready: got 1 want never asserted"); end
    endtask

    task automatic test_stall();
        wq.delete(); wq.push_back($urandom()); wq.push_back($urandom());
        run_frame(2, 1, 0, -1);
        build_exp(2);
        n_checks++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        wq.delete(); for (int i = 0; i < 3; i++) wq.push_back($urandom());
        run_frame(3, 0, 0, 4);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (bus.cfg_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 8'h00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: cfg_ready=%b in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 0 00 0",
                     bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.busy);
        end
        rst_n = 1'b1;
        wq.delete(); wq.push_back($urandom());
        run_frame(1, 0, 0, -1);
        build_exp(1);
        n_checks++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_clamp();
        wq.delete(); for (int i = 0; i < 17; i++) wq.push_back($urandom());
        run_frame(20, 0, 0, -1);
        build_exp(20);
        n_checks++; if (got.size() < 1 || got[0] !== 8'h10) begin n_fail++; $display("FAIL clamp_header: want 10, got %0d bytes", got.size()); end
        n_checks++; if (acc != 16) begin n_fail++; $display("FAIL clamp_accepted: got %0d want 16", acc); end
        n_checks++; if (over_rdy) begin n_fail++; $display("FAIL clamp_extra_ready: in_ready high after 16 words, want 0"); end
        n_checks++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL clamp_len: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int cnt, eff;
        for (int f = 0; f < 8; f++) begin
            cnt = $urandom_range(0, 20);
            eff = (cnt > MAXW) ? MAXW : cnt;
            wq.delete(); for (int i = 0; i < cnt; i++) wq.push_back($urandom());
            run_frame(cnt, 2, 3, -1);
            build_exp(cnt);
            n_checks++;
            if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", f, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_checks++;
                if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, got[i], exp_q[i]); end
            end
            n_checks++; if (acc != eff || over_rdy) begin
                n_fail++; $display("FAIL rand%0d_accepted: got %0d extra_ready=%b want %0d 0", f, acc, over_rdy, eff); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero();
        test_stall();
        test_reset_mid();
        test_clamp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
